// File: rtl/audio_pkg.sv
// Shared audio definitions: effect FSM states, default tone timing, note table.
package audio_pkg;

   // Sound-effect sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HIT   = 3'd1,
      MISS1 = 3'd2,
      GAP   = 3'd3,
      MISS2 = 3'd4
   } sfx_state_t;

   // Default effect timing at a 50 MHz clock
   localparam int unsigned DEF_HIT_HALF  = 25000;    // 1 kHz chirp
   localparam int unsigned DEF_HIT_LEN   = 5000000;  // 100 ms
   localparam int unsigned DEF_MISS_HALF = 125000;   // 200 Hz buzz
   localparam int unsigned DEF_MISS_LEN  = 7500000;  // 150 ms per beep
   localparam int unsigned DEF_GAP_LEN   = 2500000;  // 50 ms between beeps
   localparam int unsigned DEF_CNT_W     = 24;

   // Background-music note half-periods (C4..C5) in 50 MHz cycles
   localparam int unsigned NOTE_CNT = 8;
   localparam int unsigned NOTE_W   = 24;
   localparam int unsigned NOTE_HALF [NOTE_CNT] = '{
      95556, 85132, 75843, 71586, 63776, 56818, 50619, 47778
   };

   // Half-period lookup for the bgm generator
   function automatic logic [NOTE_W-1:0] note_half(input logic [2:0] idx);
      return NOTE_W'(NOTE_HALF[idx]);
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles wave every 'half' enabled cycles.
module tone_gen #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] half,
   output logic         wave
);

   logic [W-1:0] cnt;

   // Half-period counter; clear wins so every effect starts low with phase zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (enable) begin
         if (cnt == half - W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/audio_sfx_mixer.sv
// Overlays HIT / MISS sound effects on the background-music tone line.
module audio_sfx_mixer
   import audio_pkg::*;
#(
   parameter int unsigned HIT_HALF  = DEF_HIT_HALF,
   parameter int unsigned HIT_LEN   = DEF_HIT_LEN,
   parameter int unsigned MISS_HALF = DEF_MISS_HALF,
   parameter int unsigned MISS_LEN  = DEF_MISS_LEN,
   parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic bgm_in,
   input  logic hit_pulse,
   input  logic miss_pulse,
   input  logic mute,
   output logic audio_out,
   output logic sfx_busy
);

   localparam logic [CNT_W-1:0] HIT_END  = CNT_W'(HIT_LEN - 1);
   localparam logic [CNT_W-1:0] MISS_END = CNT_W'(MISS_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_LEN - 1);

   localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;
   localparam bit PARAMS_OK =
      (HIT_LEN >= 2) && (MISS_LEN >= 2) && (GAP_LEN >= 2) &&
      (HIT_HALF >= 1) && (MISS_HALF >= 1) && (CNT_W <= 32) &&
      (64'(HIT_LEN) <= CNT_LIM) && (64'(MISS_LEN) <= CNT_LIM) &&
      (64'(GAP_LEN) <= CNT_LIM) && (64'(HIT_HALF) <= CNT_LIM) &&
      (64'(MISS_HALF) <= CNT_LIM);

   sfx_state_t       state;
   sfx_state_t       state_nx;
   logic             entry;
   logic             restart;
   logic [CNT_W-1:0] dur;
   logic [CNT_W-1:0] half_sel;
   logic             tone_en;
   logic             wave;
   logic             bgm_s1;
   logic             bgm_s2;
   logic             audio_nx;

   // Two-flop synchroniser for the asynchronous bgm line (idles high)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bgm_s1 <= 1'b1;
         bgm_s2 <= 1'b1;
      end else begin
         bgm_s1 <= bgm_in;
         bgm_s2 <= bgm_s1;
      end
   end

   // Effect state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; miss always outranks hit, any pulse re-enters its state
   always_comb begin
      state_nx = state;
      restart  = 1'b0;
      case (state)
         IDLE: begin
            if (miss_pulse)     state_nx = MISS1;
            else if (hit_pulse) state_nx = HIT;
         end
         HIT: begin
            if (miss_pulse) begin
               state_nx = MISS1;
            end else if (hit_pulse) begin
               restart = 1'b1;
            end else if (dur == HIT_END) begin
               state_nx = IDLE;
            end
         end
         MISS1: begin
            if (miss_pulse)            restart  = 1'b1;
            else if (dur == MISS_END)  state_nx = GAP;
         end
         GAP: begin
            if (miss_pulse)            state_nx = MISS1;
            else if (dur == GAP_END)   state_nx = MISS2;
         end
         MISS2: begin
            if (miss_pulse)            state_nx = MISS1;
            else if (dur == MISS_END)  state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      entry = restart || (state_nx != state);
   end

   // Effect duration counter, cleared on every state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 dur <= '0;
      else if (entry)          dur <= '0;
      else if (state != IDLE)  dur <= dur + CNT_W'(1);
   end

   // Single shared tone generator, pitch selected by the active effect
   always_comb begin
      half_sel = CNT_W'(MISS_HALF);
      tone_en  = 1'b0;
      case (state)
         HIT: begin
            half_sel = CNT_W'(HIT_HALF);
            tone_en  = 1'b1;
         end
         MISS1, MISS2: tone_en = 1'b1;
         default: ;
      endcase
   end

   tone_gen #(
      .W (CNT_W)
   ) u_tone (
      .clk    (clk),
      .rst    (rst),
      .clear  (entry),
      .enable (tone_en),
      .half   (half_sel),
      .wave   (wave)
   );

   // Output source: mute, effect tone, silent gap or pass-through music
   always_comb begin
      audio_nx = 1'b1;
      if (mute)                audio_nx = 1'b1;
      else if (state == GAP)   audio_nx = 1'b1;
      else if (state != IDLE)  audio_nx = wave;
      else                     audio_nx = bgm_s2;
   end

   // Registered speaker drive and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         audio_out <= 1'b1;
         sfx_busy  <= 1'b0;
      end else begin
         audio_out <= audio_nx;
         sfx_busy  <= (state != IDLE);
      end
   end

   // Timing parameters must keep all terminal compares reachable
   always_ff @(posedge clk) begin
      if (!rst) assert (PARAMS_OK) else $error("audio_sfx_mixer: bad timing parameters");
   end

endmodule

// File: tb/tb_audio_sfx_mixer.sv
// Scoreboard bench for audio_sfx_mixer with shortened effect timing.
module tb_audio_sfx_mixer;

   localparam int unsigned HIT_HALF  = 4;
   localparam int unsigned HIT_LEN   = 32;
   localparam int unsigned MISS_HALF = 8;
   localparam int unsigned MISS_LEN  = 48;
   localparam int unsigned GAP_LEN   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bgm_in = 1'b1;
   logic hit_pulse = 1'b0;
   logic miss_pulse = 1'b0;
   logic mute = 1'b0;
   logic audio_out;
   logic sfx_busy;

   int cyc;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int    cyc;
      logic  audio;
      logic  busy;
      string tag;
   } exp_t;

   exp_t sb[$];

   audio_sfx_mixer #(
      .HIT_HALF  (HIT_HALF),
      .HIT_LEN   (HIT_LEN),
      .MISS_HALF (MISS_HALF),
      .MISS_LEN  (MISS_LEN),
      .GAP_LEN   (GAP_LEN),
      .CNT_W     (24)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bgm_in     (bgm_in),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .mute       (mute),
      .audio_out  (audio_out),
      .sfx_busy   (sfx_busy)
   );

   always #5 clk = ~clk;

   // Edge counter since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: compares DUT outputs against scoreboard entries due this cycle
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s stale entry cyc=%0d now=%0d", e.tag, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if (audio_out !== e.audio) begin
            errors++;
            $display("FAIL %s audio_out cyc=%0d got=%b exp=%b", e.tag, cyc, audio_out, e.audio);
         end
         checks++;
         if (sfx_busy !== e.busy) begin
            errors++;
            $display("FAIL %s sfx_busy cyc=%0d got=%b exp=%b", e.tag, cyc, sfx_busy, e.busy);
         end
      end
   end

   task automatic push(input int c, input logic a, input logic b, input string tag);
      exp_t e;
      int   pos;
      e.cyc = c; e.audio = a; e.busy = b; e.tag = tag;
      pos = sb.size();
      while (pos > 0 && sb[pos-1].cyc > c) pos--;
      sb.insert(pos, e);
   endtask

   task automatic push_const(input int start, input logic a, input logic b, input int n,
                             input string tag);
      for (int i = 0; i < n; i++) push(start + i, a, b, tag);
   endtask

   // Tone sample i (counted from effect start) appears at edge base+i
   task automatic push_tone(input int base, input int half, input int i0, input int i1,
                            input string tag);
      for (int i = i0; i < i1; i++) push(base + i, 1'((i / half) % 2), 1'b1, tag);
   endtask

   task automatic exp_hit(input int c0, input string tag);
      push_tone(c0 + 1, HIT_HALF, 0, HIT_LEN, tag);
      push(c0 + 33, 1'b0, 1'b0, {tag, "_end"});
   endtask

   task automatic exp_miss_tail(input int c0, input string tag);
      push_const(c0 + 49, 1'b1, 1'b1, 16, {tag, "_gap"});
      push_tone(c0 + 65, MISS_HALF, 0, MISS_LEN, {tag, "_m2"});
      push(c0 + 113, 1'b0, 1'b0, {tag, "_end"});
   endtask

   task automatic exp_miss(input int c0, input string tag);
      push_tone(c0 + 1, MISS_HALF, 0, MISS_LEN, {tag, "_m1"});
      exp_miss_tail(c0, tag);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick(1);
   endtask

   // One-cycle pulse; c0 is the edge that samples it
   task automatic pulse(input logic h, input logic m, output int c0);
      hit_pulse  = h;
      miss_pulse = m;
      tick(1);
      c0 = cyc;
      hit_pulse  = 1'b0;
      miss_pulse = 1'b0;
   endtask

   task automatic check_now(input string tag, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int c1;
      int dummy;
      logic lvl;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check_now("reset_audio", audio_out, 1'b1);
      check_now("reset_busy", sfx_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick(1);

      // bgm pass-through with 3-edge latency
      push_const(1, 1'b1, 1'b0, 3, "bgm_init");
      for (int n = 1; n <= 60; n++) begin
         lvl = ((n / 10) % 2) == 0;
         bgm_in = lvl;
         push(n + 3, lvl, 1'b0, "bgm");
         tick(1);
      end
      bgm_in = 1'b0;
      push(cyc + 3, 1'b0, 1'b0, "bgm_low");
      tick(4);

      // Plain HIT
      pulse(1'b1, 1'b0, c0);
      exp_hit(c0, "hit");
      wait_cyc(c0 + 36);

      // HIT restarted by a second hit
      pulse(1'b1, 1'b0, c0);
      push_tone(c0 + 1, HIT_HALF, 0, 6, "hit_a");
      wait_cyc(c0 + 5);
      pulse(1'b1, 1'b0, c1);
      exp_hit(c1, "hit_restart");
      wait_cyc(c1 + 36);

      // Plain MISS double beep
      pulse(1'b0, 1'b1, c0);
      exp_miss(c0, "miss");
      wait_cyc(c0 + 116);

      // Simultaneous hit+miss, then hits in MISS1 and GAP are ignored
      pulse(1'b1, 1'b1, c0);
      exp_miss(c0, "both");
      wait_cyc(c0 + 20);
      pulse(1'b1, 1'b0, dummy);
      wait_cyc(c0 + 54);
      pulse(1'b1, 1'b0, dummy);
      wait_cyc(c0 + 116);

      // MISS preempts HIT after 10 cycles
      pulse(1'b1, 1'b0, c0);
      push_tone(c0 + 1, HIT_HALF, 0, 10, "pre_hit");
      wait_cyc(c0 + 9);
      pulse(1'b0, 1'b1, c1);
      exp_miss(c1, "preempt");
      wait_cyc(c1 + 116);

      // Mute during MISS1 for 20 cycles
      pulse(1'b0, 1'b1, c0);
      push_tone(c0 + 1, MISS_HALF, 0, 10, "mute_pre");
      push_const(c0 + 11, 1'b1, 1'b1, 20, "muted");
      push_tone(c0 + 1, MISS_HALF, 30, MISS_LEN, "mute_post");
      exp_miss_tail(c0, "mute");
      wait_cyc(c0 + 10);
      mute = 1'b1;
      wait_cyc(c0 + 30);
      mute = 1'b0;
      wait_cyc(c0 + 116);

      // Asynchronous reset in the middle of HIT
      pulse(1'b1, 1'b0, c0);
      push_tone(c0 + 1, HIT_HALF, 0, 12, "pre_rst");
      wait_cyc(c0 + 12);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_now("async_rst_audio", audio_out, 1'b1);
      check_now("async_rst_busy", sfx_busy, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      push_const(1, 1'b1, 1'b0, 2, "post_rst_sync");
      push_const(3, 1'b0, 1'b0, 40, "post_rst_quiet");
      wait_cyc(45);

      // Every expected entry must have been consumed
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
